// File: rtl/lfsr_gen.sv
// lfsr_gen: XNOR Galois LFSR word generator with a valid/ready output port.
// Every output word is STRIDE LFSR steps after the previous one. A seed can be
// loaded at any time, and an all-ones seed (the XNOR lock-up state) is replaced
// by SEED.
module lfsr_gen #(
    parameter int unsigned       WIDTH  = 16,
    parameter logic [WIDTH-1:0]  TAPS   = 16'hA010,
    parameter logic [WIDTH-1:0]  SEED   = 16'hABCD,
    parameter int unsigned       OUT_W  = 16,
    parameter int unsigned       STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  seed_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic [WIDTH-1:0]  lfsr_q,
    output logic              lockup
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] STRIDE_C = CNT_W'(STRIDE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] lfsr_nxt;
    logic             seed_bad;

    // One LFSR step: the MSB feeds bit 0 and is XNORed into every tapped bit.
    // The step is invertible and all-ones is its only fixed point, so any
    // other state can never reach all-ones.
    always_comb begin
        lfsr_nxt    = '0;
        lfsr_nxt[0] = lfsr_q[WIDTH-1];
        for (int i = 1; i < int'(WIDTH); i++) begin
            if (TAPS[i]) begin
                lfsr_nxt[i] = ~(lfsr_q[i-1] ^ lfsr_q[WIDTH-1]);
            end else begin
                lfsr_nxt[i] = lfsr_q[i-1];
            end
        end
    end

    assign cnt_inc  = cnt + CNT_W'(1);
    assign seed_bad = &seed_in;
    assign out_data = lfsr_q[OUT_W-1:0];

    // Control FSM, step counter, LFSR state and registered flags.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            cnt       <= '0;
            lfsr_q    <= SEED;
            out_valid <= 1'b0;
            lockup    <= 1'b0;
        end else begin
            lockup <= 1'b0;
            if (load) begin
                // A load overrides everything and discards any pending word.
                lfsr_q    <= seed_bad ? SEED : seed_in;
                lockup    <= seed_bad;
                out_valid <= 1'b0;
                cnt       <= '0;
                state     <= en ? STEP : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        out_valid <= 1'b0;
                        if (en) begin
                            state <= STEP;
                            cnt   <= '0;
                        end
                    end
                    STEP: begin
                        // With en low the state, the counter and the LFSR all hold.
                        if (en) begin
                            lfsr_q <= lfsr_nxt;
                            cnt    <= cnt_inc;
                            if (cnt_inc == STRIDE_C) begin
                                state     <= VALID;
                                out_valid <= 1'b1;
                            end
                        end
                    end
                    VALID: begin
                        // The word is held until it is consumed, whatever en does.
                        // The transfer step counts as the first step of the next word.
                        if (out_ready) begin
                            lfsr_q <= lfsr_nxt;
                            if (!en) begin
                                state     <= IDLE;
                                out_valid <= 1'b0;
                                cnt       <= '0;
                            end else if (STRIDE == 1) begin
                                state     <= VALID;
                                out_valid <= 1'b1;
                                cnt       <= CNT_W'(1);
                            end else begin
                                state     <= STEP;
                                out_valid <= 1'b0;
                                cnt       <= CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        cnt       <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: one instance with the defaults (STRIDE=1) and
// one with STRIDE=4. All expected words are worked out by hand from the
// step rule with TAPS=16'hA010.
module tb_lfsr_gen;

    logic        clk;
    logic        rst_b;

    logic        en, load, out_ready;
    logic [15:0] seed_in;
    logic        out_valid, lockup;
    logic [15:0] out_data, lfsr_q;

    logic        en4, load4, out_ready4;
    logic [15:0] seed_in4;
    logic        out_valid4, lockup4;
    logic [15:0] out_data4, lfsr_q4;

    int n_checks;
    int n_errors;

    lfsr_gen u_dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .en        (en),
        .load      (load),
        .seed_in   (seed_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .lfsr_q    (lfsr_q),
        .lockup    (lockup)
    );

    lfsr_gen #(.STRIDE(4)) u_dut4 (
        .clk       (clk),
        .rst_b     (rst_b),
        .en        (en4),
        .load      (load4),
        .seed_in   (seed_in4),
        .out_ready (out_ready4),
        .out_valid (out_valid4),
        .out_data  (out_data4),
        .lfsr_q    (lfsr_q4),
        .lockup    (lockup4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [15:0] q, input logic v);
        check_eq({tag, "_q"}, 64'(lfsr_q), 64'(q));
        check_eq({tag, "_v"}, 64'(out_valid), 64'(v));
    endtask

    task automatic chk4(input string tag, input logic [15:0] q, input logic v);
        check_eq({tag, "_q"}, 64'(lfsr_q4), 64'(q));
        check_eq({tag, "_v"}, 64'(out_valid4), 64'(v));
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_b      = 1'b0;
        en         = 1'b0; load  = 1'b0; out_ready  = 1'b0; seed_in  = 16'h0000;
        en4        = 1'b0; load4 = 1'b0; out_ready4 = 1'b0; seed_in4 = 16'h0000;

        // Reset values
        tick(); tick();
        chk1("rst", 16'hABCD, 1'b0);
        check_eq("rst_lockup", 64'(lockup), 64'd0);
        chk4("rst4", 16'hABCD, 1'b0);
        rst_b = 1'b1;
        tick(); tick();
        chk1("idle_hold", 16'hABCD, 1'b0);

        // IDLE -> STEP -> VALID, word held while out_ready is low
        en = 1'b1;
        tick();
        chk1("step", 16'hABCD, 1'b0);
        tick();
        chk1("first", 16'h579B, 1'b1);
        check_eq("first_data", 64'(out_data), 64'h579B);
        tick(); tick();
        chk1("held", 16'h579B, 1'b1);
        en = 1'b0;
        tick();
        chk1("held_en0", 16'h579B, 1'b1);
        en = 1'b1;

        // Back-to-back transfers with STRIDE=1
        out_ready = 1'b1;
        tick();
        chk1("xfer1", 16'h0F26, 1'b1);
        out_ready = 1'b0;
        tick();
        chk1("xfer1_hold", 16'h0F26, 1'b1);
        out_ready = 1'b1;
        tick();
        chk1("xfer2", 16'hBE5C, 1'b1);

        // Transfer with en low steps once and returns to IDLE
        en = 1'b0;
        tick();
        chk1("xfer_idle", 16'h7CB9, 1'b0);
        out_ready = 1'b0;
        tick();
        chk1("idle2", 16'h7CB9, 1'b0);

        // All-ones seed is replaced and lockup pulses for one cycle
        load = 1'b1; seed_in = 16'hFFFF;
        tick();
        chk1("ld_ones", 16'hABCD, 1'b0);
        check_eq("lockup_on", 64'(lockup), 64'd1);
        load = 1'b0;
        tick();
        check_eq("lockup_off", 64'(lockup), 64'd0);
        load = 1'b1; seed_in = 16'h1234;
        tick();
        chk1("ld_1234", 16'h1234, 1'b0);
        check_eq("lockup_ok", 64'(lockup), 64'd0);
        load = 1'b0;

        // Reset while a word is valid takes effect without a clock edge
        en = 1'b1;
        tick();
        tick();
        chk1("w1234", 16'h8478, 1'b1);
        #2;
        rst_b = 1'b0;
        #1;
        chk1("async_rst", 16'hABCD, 1'b0);
        en = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        chk1("post_rst", 16'hABCD, 1'b0);

        // STRIDE=4: pause mid-STEP freezes progress
        en4 = 1'b1;
        tick();
        chk4("s4_step0", 16'hABCD, 1'b0);
        tick();
        chk4("s4_step1", 16'h579B, 1'b0);
        tick();
        chk4("s4_step2", 16'h0F26, 1'b0);
        en4 = 1'b0;
        tick(); tick();
        chk4("s4_pause", 16'h0F26, 1'b0);
        en4 = 1'b1;
        tick();
        chk4("s4_step3", 16'hBE5C, 1'b0);
        tick();
        chk4("s4_word", 16'h7CB9, 1'b1);

        // STRIDE=4: load beats a simultaneous transfer
        load4 = 1'b1; seed_in4 = 16'h0001; out_ready4 = 1'b1;
        tick();
        chk4("s4_load", 16'h0001, 1'b0);
        load4 = 1'b0; out_ready4 = 1'b0;
        tick();
        chk4("s4_l1", 16'hA012, 1'b0);
        tick();
        chk4("s4_l2", 16'h4025, 1'b0);
        tick();
        chk4("s4_l3", 16'h205A, 1'b0);
        tick();
        chk4("s4_l4", 16'hE0A4, 1'b1);
        check_eq("s4_l4_data", 64'(out_data4), 64'hE0A4);

        // STRIDE=4: transfer with en high counts as the first step
        out_ready4 = 1'b1;
        tick();
        chk4("s4_x1", 16'hC149, 1'b0);
        out_ready4 = 1'b0;
        tick();
        chk4("s4_x2", 16'h8293, 1'b0);
        tick();
        chk4("s4_x3", 16'h0527, 1'b0);
        tick();
        chk4("s4_x4", 16'hAA5E, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the LFSR state width (legal 3..64).
REQ-002 Parameter TAPS, default 16'hA010, SHALL be the WIDTH-bit XNOR tap mask, with bit i set meaning state bit i receives an XNOR with feedback.
REQ-003 Parameter SEED, default 16'hABCD, SHALL be the WIDTH-bit reset and substitute value, never all-ones.
REQ-004 Parameter OUT_W, default 16, SHALL set the output word width (legal 1..WIDTH).
REQ-005 Parameter STRIDE, default 1, SHALL set the LFSR steps between consecutive output words (legal 1..255).
REQ-006 clk  in  1  SHALL be the single clock, rising-edge active.
REQ-007 rst_b  in  1  SHALL be the asynchronous, active-low reset.
REQ-008 en  in  1  SHALL enable generation; when low, stepping is paused.
REQ-009 load  in  1  SHALL be a single-cycle request to load seed_in.
REQ-010 seed_in  in  WIDTH  SHALL be the seed value, sampled when load=1.
REQ-011 out_ready  in  1  SHALL be the consumer-ready signal.
REQ-012 out_valid  out  1  SHALL indicate that out_data holds a fresh word.
REQ-013 out_data  out  OUT_W  SHALL equal lfsr_q[OUT_W-1:0].
REQ-014 lfsr_q  out  WIDTH  SHALL expose the full current LFSR state.
REQ-015 lockup  out  1  SHALL be a one-cycle pulse when an all-ones seed is rejected.

Function
REQ-016 One step SHALL compute fb = lfsr_q[WIDTH-1]; next[0] = fb; next[i] = TAPS[i] ? (lfsr_q[i-1] XNOR fb) : lfsr_q[i-1] for i = 1..WIDTH-1.
REQ-017 The FSM SHALL have three states: IDLE, STEP and VALID, plus an 8-bit step counter cnt.
REQ-018 IDLE SHALL hold the LFSR and keep out_valid=0; when en=1, the FSM SHALL move to STEP with cnt=0.
REQ-019 STEP with en=1 SHALL advance the LFSR one step per cycle and increment cnt; on the cycle cnt reaches STRIDE, the FSM SHALL enter VALID.
REQ-020 STEP with en=0 SHALL freeze the LFSR, cnt and state (pause, not abort).
REQ-021 VALID SHALL hold out_valid=1, with out_data and lfsr_q stable until a transfer (out_valid & out_ready), regardless of en.
REQ-022 A transfer cycle SHALL advance the LFSR one step; if en=1 and STRIDE=1, the FSM SHALL stay in VALID (one word per cycle); if en=1 and STRIDE>1, it SHALL go to STEP with cnt=1; if en=0, it SHALL go to IDLE.
REQ-023 load SHALL take priority over all stepping and transfers in the same cycle.
REQ-024 A load SHALL set lfsr_q = seed_in, or SEED when seed_in is all-ones, in which case lockup pulses for one cycle.
REQ-025 A load SHALL drop out_valid on the next cycle, discarding any pending word, and SHALL set the FSM to STEP with cnt=0 if en=1, else to IDLE.
REQ-026 lfsr_q SHALL never take the all-ones value.
REQ-027 cnt SHALL never exceed STRIDE, and SHALL not wrap.

Reset
REQ-028 While rst_b=0, the block SHALL asynchronously set lfsr_q=SEED, FSM=IDLE, cnt=0, out_valid=0 and lockup=0.
REQ-029 Reset deassertion SHALL take effect at the next rising clk edge, and reset mid-word SHALL discard that word.

Verification
REQ-030 Defaults, reset, then en=1 with out_ready=0 -> one STEP cycle, then out_valid=1 with out_data=16'h579B held indefinitely.
REQ-031 From REQ-030, out_ready=1 for one cycle -> transfer, then out_data=16'h0F26 with out_valid staying 1 (back-to-back).
REQ-032 load=1 with seed_in=16'hFFFF -> lfsr_q=16'hABCD and lockup=1 for exactly one cycle.
REQ-033 With STRIDE=4 and out_valid=1, a load of seed_in=16'h0001 in the same cycle as out_ready=1 -> the load wins, out_valid=0, and valid returns after 4 steps.
REQ-034 en toggled low mid-STEP with STRIDE=4 -> lfsr_q and cnt frozen, and completion occurs after the remaining steps once en=1.
REQ-035 rst_b asserted while out_valid=1 -> out_valid=0 and lfsr_q=16'hABCD without waiting for a clk edge.
